param_counter: RTL

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/cnt_pkg.sv | 15 +
 rtl/cnt_prescaler.sv | 38 +++
 rtl/param_counter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared definitions for the parameterised counter.
//   cnt_mode_e    : CNT_WRAP (modulo count) or CNT_SAT (saturate, one-shot)
//   CNT_DEF_WIDTH : default counter register width
//   CNT_DEF_MAX   : default terminal value
package cnt_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int          CNT_DEF_WIDTH = 27;
  localparam int unsigned CNT_DEF_MAX   = 99_999_999;

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: divides the count enable by PRESCALE. It emits one step pulse
// on every PRESCALE-th cycle in which en is high. Disabled cycles do not
// advance the divider.
// Ports:
//   clk  in  : clock, rising edge
//   rst  in  : synchronous reset, active-low
//   clr  in  : synchronous clear of the divider (the counter's clr or load)
//   en   in  : enable to be divided
//   step out : divided enable, combinational from en and the divider state
module cnt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] div_p0;

  // Stage p0: divider register
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_p0 <= '0;
    end else if (clr) begin
      div_p0 <= '0;
    end else if (en) begin
      div_p0 <= (div_p0 == LAST) ? '0 : div_p0 + 1'b1;
    end
  end

  assign step = en && (div_p0 == LAST);

endmodule

// File: rtl/param_counter.sv
// param_counter: up/down counter over 0..MAX_VAL with wrap or saturate mode,
// synchronous clear and load, and cascade outputs.
// Optional feature: define CNT_PRESCALER_EN to gate steps through cnt_prescaler
// (one step per PRESCALE enabled cycles). Without it, en steps directly and
// PRESCALE has no effect.
// Ports:
//   clk      in          : clock, rising edge
//   rst      in          : synchronous reset, active-low
//   clr      in          : synchronous clear to 0
//   en       in          : count enable
//   up       in          : direction, 1 = increment, 0 = decrement
//   load     in          : synchronous load strobe
//   load_val in  [WIDTH] : load value, clamped to MAX_VAL
//   q        out [WIDTH] : registered count
//   cnt_max  out         : q == MAX_VAL
//   cnt_min  out         : q == 0
//   tc       out         : carry/borrow for cascading, step enable AND boundary
//   done     out         : sticky boundary-reached flag, CNT_SAT mode only
module param_counter
  import cnt_pkg::*;
#(
  parameter int          WIDTH    = CNT_DEF_WIDTH,
  parameter int unsigned MAX_VAL  = CNT_DEF_MAX,
  parameter cnt_mode_e   MODE     = CNT_WRAP,
  parameter int          PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             cnt_max,
  output logic             cnt_min,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  if ((64'(MAX_VAL) >= (64'd1 << WIDTH)) || (MAX_VAL == 0) || (PRESCALE < 1)) begin : g_bad_cfg
    $error("param_counter: illegal configuration (MAX_VAL must be 1..2**WIDTH-1, PRESCALE >= 1)");
  end

  // Out-of-range load values clamp to the terminal value.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  // At a boundary, wrap mode rolls over and saturate mode holds. The
  // arithmetic never leaves 0..MAX_VAL, so WIDTH bits always suffice.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    if (v == MAX_Q) return (MODE == CNT_SAT) ? MAX_Q : '0;
    return v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    if (v == '0) return (MODE == CNT_SAT) ? '0 : MAX_Q;
    return v - 1'b1;
  endfunction

  logic             step_en;
  logic [WIDTH-1:0] count_p0;
  logic [WIDTH-1:0] count_nxt;
  logic             done_p0;
  logic             done_nxt;

`ifdef CNT_PRESCALER_EN
  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr | load),
    .en   (en),
    .step (step_en)
  );
`else
  assign step_en = en;
`endif

  always_comb begin
    count_nxt = count_p0;
    done_nxt  = done_p0;
    if (clr) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
    end else if (load) begin
      count_nxt = sat_load(load_val);
      done_nxt  = 1'b0;
    end else if (step_en) begin
      count_nxt = up ? step_up(count_p0) : step_down(count_p0);
      // A step that only holds at the boundary does not count as landing on it.
      if ((count_nxt != count_p0) && (up ? (count_nxt == MAX_Q) : (count_nxt == '0))) begin
        done_nxt = 1'b1;
      end
    end
    if (MODE != CNT_SAT) done_nxt = 1'b0;
  end

  // Stage p0: count and done registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_p0 <= '0;
      done_p0  <= 1'b0;
    end else begin
      count_p0 <= count_nxt;
      done_p0  <= done_nxt;
    end
  end

  assign q       = count_p0;
  assign done    = done_p0;
  assign cnt_max = (count_p0 == MAX_Q);
  assign cnt_min = (count_p0 == '0);
  assign tc      = step_en && (up ? cnt_max : cnt_min);

endmodule
